// File: rtl/led_pio_blink_if.sv
// Avalon-MM slave port bundle for the LED PIO: address/select/strobe toward the
// slave, combinational read data back to the master.
interface led_pio_blink_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/led_pio_blink.sv
// LED output bank with atomic set/clear/toggle registers and a free-running
// blink prescaler that gates selected bits with a square-wave phase.
module led_pio_blink #(
  parameter int          WIDTH    = 10,
  parameter int          DIV_W    = 26,
  parameter logic [31:0] DATA_RST = 32'd0,
  parameter logic [31:0] DIV_RST  = 32'd25000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  led_pio_blink_if.slave       bus,
  output logic [WIDTH-1:0]     out_port,
  output logic                 blink_tick
);

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_BLINK   = 3'd1,
    REG_DIVIDER = 3'd2,
    REG_STATUS  = 3'd3,
    REG_OUTSET  = 3'd4,
    REG_OUTCLR  = 3'd5,
    REG_OUTTGL  = 3'd6,
    REG_NONE    = 3'd7
  } reg_addr_t;

  localparam logic [WIDTH-1:0] DATA_INIT = DATA_RST[WIDTH-1:0];
  localparam logic [DIV_W-1:0] DIV_INIT  = DIV_RST[DIV_W-1:0];

  reg_addr_t          addr;
  logic               wr;
  logic               wr_div;
  logic [WIDTH-1:0]   wd_bits;
  logic [DIV_W-1:0]   wd_div;
  logic               unused_wd;

  logic [WIDTH-1:0]   data_reg;
  logic [WIDTH-1:0]   blink_reg;
  logic [DIV_W-1:0]   divider_reg;
  logic [DIV_W-1:0]   cnt;
  logic               phase;

  logic [DIV_W-1:0]   cnt_next;
  logic               phase_next;
  logic               tick;

  assign addr      = reg_addr_t'(bus.address);
  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_div    = wr && (addr == REG_DIVIDER);
  assign wd_bits   = bus.writedata[WIDTH-1:0];
  assign wd_div    = bus.writedata[DIV_W-1:0];
  assign unused_wd = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg    <= DATA_INIT;
      blink_reg   <= '0;
      divider_reg <= DIV_INIT;
    end else if (wr) begin
      case (addr)
        REG_DATA:    data_reg    <= wd_bits;
        REG_BLINK:   blink_reg   <= wd_bits;
        REG_DIVIDER: divider_reg <= wd_div;
        REG_OUTSET:  data_reg    <= data_reg | wd_bits;
        REG_OUTCLR:  data_reg    <= data_reg & ~wd_bits;
        REG_OUTTGL:  data_reg    <= data_reg ^ wd_bits;
        default:     ;
      endcase
    end
  end

  // A DIVIDER write restarts the half-period so a smaller value can never be overrun.
  always_comb begin
    cnt_next   = cnt;
    phase_next = phase;
    tick       = 1'b0;
    if (wr_div || (divider_reg == '0)) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (cnt == divider_reg) begin
      cnt_next   = '0;
      phase_next = ~phase;
      tick       = 1'b1;
    end else begin
      cnt_next = cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

  assign blink_tick = tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= DATA_INIT;
    end else begin
      out_port <= data_reg & (~blink_reg | {WIDTH{phase}});
    end
  end

  // Write-only and unmapped addresses read back as zero.
  always_comb begin
    bus.readdata = '0;
    case (addr)
      REG_DATA:    bus.readdata[WIDTH-1:0] = data_reg;
      REG_BLINK:   bus.readdata[WIDTH-1:0] = blink_reg;
      REG_DIVIDER: bus.readdata[DIV_W-1:0] = divider_reg;
      REG_STATUS:  bus.readdata[0]         = phase;
      default:     bus.readdata            = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_blink.sv
// Self-checking bench for led_pio_blink: an elapsed-time blink model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_led_pio_blink;
  localparam int W    = 10;
  localparam int DW   = 26;
  localparam int DIVR = 25000000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] out_port;
  logic         blink_tick;

  led_pio_blink_if bus();

  led_pio_blink #(
    .WIDTH(W), .DIV_W(DW), .DATA_RST(32'd0), .DIV_RST(DIVR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .out_port(out_port), .blink_tick(blink_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Model: phase derived from cycles elapsed since the last restart.
  logic [W-1:0] m_data, m_blink, m_out;
  int           m_div;
  int           m_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_phase(input int t, input int d);
    if (d == 0) return 1'b1;
    return ((t / (d + 1)) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_data);
      3'd1:    return 32'(m_blink);
      3'd2:    return 32'(m_div);
      3'd3:    return 32'(m_phase(m_t, m_div));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_tick();
    logic div_wr;
    div_wr = bus.chipselect && !bus.write_n && (bus.address == 3'd2);
    return reset_n && (m_div != 0) && ((m_t % (m_div + 1)) == m_div) && !div_wr;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data  <= '0;
      m_blink <= '0;
      m_div   <= DIVR;
      m_t     <= 0;
      m_out   <= '0;
    end else begin
      m_out <= m_data & (~m_blink | {W{m_phase(m_t, m_div)}});
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          3'd0: m_data  <= bus.writedata[W-1:0];
          3'd1: m_blink <= bus.writedata[W-1:0];
          3'd2: m_div   <= int'(bus.writedata[DW-1:0]);
          3'd4: m_data  <= m_data | bus.writedata[W-1:0];
          3'd5: m_data  <= m_data & ~bus.writedata[W-1:0];
          3'd6: m_data  <= m_data ^ bus.writedata[W-1:0];
          default: ;
        endcase
      end
      if ((bus.chipselect && !bus.write_n && bus.address == 3'd2) || m_div == 0)
        m_t <= 0;
      else
        m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("out_port", 32'(out_port), 32'(m_out));
      checkOutput("blink_tick", 32'(blink_tick), 32'(exp_tick()));
      checkOutput("readdata", bus.readdata, m_read(bus.address));
    end
  end

  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #2;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic readCheck(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #2;
    checkOutput(name, bus.readdata, exp);
    @(posedge clk);
    #2;
    bus.chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int last, nt, gap_bad, bit1_bad, first;
    bit seen2, seen3;
    logic [2:0]  ra;
    logic [31:0] rd;

    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    #1 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    $display("[TB] reset register map");
    for (int a = 0; a < 8; a++)
      readCheck("t1_read", 3'(a), (a == 2) ? 32'(DIVR) : (a == 3) ? 32'd1 : 32'd0);
    checkOutput("t1_out", 32'(out_port), 32'd0);

    $display("[TB] atomic set/clear/toggle");
    applyStimulus(3'd0, 32'h3F0);
    applyStimulus(3'd4, 32'h00F);
    #2 checkOutput("t2_out_before", 32'(out_port), 32'h3F0);
    @(posedge clk);
    #2 checkOutput("t2_out_after", 32'(out_port), 32'h3FF);
    applyStimulus(3'd5, 32'h300);
    applyStimulus(3'd6, 32'h0C1);
    readCheck("t2_data", 3'd0, 32'h03E);
    checkOutput("t2_out_final", 32'(out_port), 32'h03E);

    $display("[TB] blink with divider 3");
    applyStimulus(3'd0, 32'h003);
    applyStimulus(3'd1, 32'h001);
    applyStimulus(3'd2, 32'd3);
    last = -1; nt = 0; gap_bad = 0; bit1_bad = 0; seen2 = 0; seen3 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (blink_tick) begin
        if (last >= 0 && i - last != 4) gap_bad++;
        last = i;
        nt++;
      end
      if (out_port == 10'h003) seen3 = 1'b1;
      if (out_port == 10'h002) seen2 = 1'b1;
      if (!out_port[1]) bit1_bad++;
    end
    @(posedge clk);
    #2;
    checkOutput("t3_ticks", 32'(nt), 32'd4);
    checkOutput("t3_gap", 32'(gap_bad), 32'd0);
    checkOutput("t3_seen", {30'd0, seen3, seen2}, 32'd3);
    checkOutput("t3_bit1", 32'(bit1_bad), 32'd0);

    $display("[TB] divider rewrite mid-count");
    applyStimulus(3'd2, 32'd9);
    idle(7);
    bus.address    = 3'd2;
    bus.writedata  = 32'd2;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    checkOutput("t4_no_tick", 32'(blink_tick), 32'd0);
    @(posedge clk);
    #2;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd3;
    first = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput("t4_phase", bus.readdata, 32'd1);
      if (blink_tick && first < 0) first = i;
    end
    @(posedge clk);
    #2;
    checkOutput("t4_next_tick", 32'(first), 32'd3);

    $display("[TB] divider zero while phase low");
    applyStimulus(3'd2, 32'd3);
    idle(4);
    readCheck("t5_phase0", 3'd3, 32'd0);
    applyStimulus(3'd2, 32'd0);
    readCheck("t5_phase1", 3'd3, 32'd1);
    nt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (blink_tick) nt++;
    end
    @(posedge clk);
    #2;
    checkOutput("t5_ticks", 32'(nt), 32'd0);
    checkOutput("t5_out", 32'(out_port), 32'h003);

    $display("[TB] async reset mid-blink and ignored writes");
    applyStimulus(3'd2, 32'd1);
    applyStimulus(3'd1, 32'h3FF);
    applyStimulus(3'd0, 32'h155);
    idle(5);
    bus.address    = 3'd0;
    bus.writedata  = 32'h2AA;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t6_out", 32'(out_port), 32'd0);
    checkOutput("t6_tick", 32'(blink_tick), 32'd0);
    checkOutput("t6_rd_data", bus.readdata, 32'd0);
    #2 bus.address = 3'd2;
    #1 checkOutput("t6_rd_div", bus.readdata, 32'(DIVR));
    bus.address = 3'd3;
    #1 checkOutput("t6_rd_status", bus.readdata, 32'd1);
    @(posedge clk);
    #2;
    checkOutput("t6_out_held", 32'(out_port), 32'd0);
    reset_n        = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    applyStimulus(3'd7, 32'hFFFF_FFFF);
    for (int a = 0; a < 7; a++)
      readCheck("t6_read", 3'(a), (a == 2) ? 32'(DIVR) : (a == 3) ? 32'd1 : 32'd0);
    applyStimulus(3'd0, 32'hFFFF_FFFF);
    readCheck("t6_data_mask", 3'd0, 32'h3FF);
    applyStimulus(3'd5, 32'hFFFF_FC00);
    readCheck("t6_clr_upper", 3'd0, 32'h3FF);
    applyStimulus(3'd1, 32'hFFFF_F000);
    readCheck("t6_blink_mask", 3'd1, 32'd0);
    applyStimulus(3'd2, 32'hFFFF_FFFF);
    readCheck("t6_div_mask", 3'd2, 32'h3FF_FFFF);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      ra = 3'($urandom_range(0, 7));
      rd = $urandom;
      if (ra == 3'd2) rd = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 3) != 0) begin
        applyStimulus(ra, rd);
      end else begin
        bus.address = ra;
        idle(1);
      end
      idle($urandom_range(0, 2));
    end

    idle(2);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
